otter_exec_unit: RTL and testbench

Execute-stage arithmetic block for the OTTER RV32I pipeline. Combines the ALU, the branch address generator, and the branch condition generator. Adds one registered copy of the ALU result with a valid bit, forming the EX/MEM result register. All address and compare outputs are combinational so the decode/PC-select logic can use them in the same cycle.

---
 rtl/otter_pkg.sv | 36 +++
 rtl/otter_alu.sv | 42 ++++
 rtl/otter_exec_unit.sv | 132 +++++++++++++
 tb/tb_otter_exec_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// -----------------------------------------------------------------------------
// otter_pkg
// Shared definitions for the OTTER RV32I execute stage:
//   - alu_fun_t : ALU operation encoding driven by the control decoder
//   - F3_*      : branch funct3 codes used by the optional branch-taken logic
//   - XLEN      : datapath width
// No ports (package).
// -----------------------------------------------------------------------------
package otter_pkg;

  localparam int XLEN = 32;

  // ALU operation codes; bit 3 selects the "alternate" form (sub / sra).
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_LUI  = 4'b1001,
    ALU_SRA  = 4'b1101
  } alu_fun_t;

  // Branch condition funct3 codes (010/011 are not branches).
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/otter_alu.sv
// -----------------------------------------------------------------------------
// otter_alu
// Purely combinational RV32I ALU.
// Ports:
//   SRC_A   in  32  operand A (already forwarded / muxed)
//   SRC_B   in  32  operand B; shifts use SRC_B[4:0] only
//   ALU_FUN in   4  operation code (otter_pkg::alu_fun_t); unknown codes -> 0
//   RESULT  out 32  operation result, modulo 2^32, no flags
// -----------------------------------------------------------------------------
module otter_alu
  import otter_pkg::*;
(
  input  logic [31:0] SRC_A,
  input  logic [31:0] SRC_B,
  input  logic [3:0]  ALU_FUN,
  output logic [31:0] RESULT
);

  logic [4:0] shamt;

  assign shamt = SRC_B[4:0];

  always_comb begin
    // NOTE: default assigned first so every path drives RESULT and no latch is inferred.
    RESULT = '0;
    case (ALU_FUN)
      ALU_ADD:  RESULT = SRC_A + SRC_B;
      ALU_SUB:  RESULT = SRC_A - SRC_B;
      ALU_SLL:  RESULT = SRC_A << shamt;
      ALU_SLT:  RESULT = {31'b0, ($signed(SRC_A) < $signed(SRC_B))};
      ALU_SLTU: RESULT = {31'b0, (SRC_A < SRC_B)};
      ALU_XOR:  RESULT = SRC_A ^ SRC_B;
      ALU_SRL:  RESULT = SRC_A >> shamt;
      ALU_SRA:  RESULT = $unsigned($signed(SRC_A) >>> shamt);
      ALU_OR:   RESULT = SRC_A | SRC_B;
      ALU_AND:  RESULT = SRC_A & SRC_B;
      ALU_LUI:  RESULT = SRC_A;
      default:  RESULT = '0;
    endcase
  end

endmodule

// File: rtl/otter_exec_unit.sv
// -----------------------------------------------------------------------------
// otter_exec_unit
// OTTER RV32I execute stage: ALU, branch address generator (BAG), branch
// condition generator (BCG) and the EX/MEM result register.
// All address/compare outputs are combinational so PC-select logic can use
// them in the same cycle.
//
// Ports:
//   CLK, RST          clock; synchronous active-high reset
//   EN                pipeline advance (0 = stall, hold RESULT_Q/VALID_Q)
//   VALID             current op is a real, non-flushed instruction
//   SRC_A, SRC_B      ALU operands
//   ALU_FUN           ALU operation code
//   RS1, RS2          forwarded register values (compare operands, JALR base)
//   PC                PC of the instruction being resolved
//   I_TYPE, B_TYPE, J_TYPE  sign-extended immediates
//   RESULT            combinational ALU result
//   JAL, JALR, BRANCH combinational target addresses
//   BR_EQ, BR_LT, BR_LTU  combinational RS1/RS2 compares
//   RESULT_Q, VALID_Q registered RESULT / VALID
//
// Build option EXEC_BR_TAKEN_EN: adds input FUNCT3[2:0] and output BR_TAKEN,
// the VALID-qualified branch decision. Without it the control decoder resolves
// the branch from BR_EQ/BR_LT/BR_LTU.
// -----------------------------------------------------------------------------
module otter_exec_unit
  import otter_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        VALID,
  input  logic [31:0] SRC_A,
  input  logic [31:0] SRC_B,
  input  logic [3:0]  ALU_FUN,
  input  logic [31:0] RS1,
  input  logic [31:0] RS2,
  input  logic [31:0] PC,
  input  logic [31:0] I_TYPE,
  input  logic [31:0] B_TYPE,
  input  logic [31:0] J_TYPE,
`ifdef EXEC_BR_TAKEN_EN
  input  logic [2:0]  FUNCT3,
  output logic        BR_TAKEN,
`endif
  output logic [31:0] RESULT,
  output logic [31:0] JAL,
  output logic [31:0] JALR,
  output logic [31:0] BRANCH,
  output logic        BR_EQ,
  output logic        BR_LT,
  output logic        BR_LTU,
  output logic [31:0] RESULT_Q,
  output logic        VALID_Q
);

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  otter_alu u_alu (
    .SRC_A   (SRC_A),
    .SRC_B   (SRC_B),
    .ALU_FUN (ALU_FUN),
    .RESULT  (RESULT)
  );

  // ---------------------------------------------------------------------------
  // Branch address generator
  // ---------------------------------------------------------------------------
  logic [31:0] jalr_sum;

  assign JAL      = PC + J_TYPE;
  assign BRANCH   = PC + B_TYPE;
  assign jalr_sum = RS1 + I_TYPE;
  // JALR target always clears bit 0.
  assign JALR     = {jalr_sum[31:1], 1'b0};

  // ---------------------------------------------------------------------------
  // Branch condition generator (RS1/RS2 only, never the ALU operands)
  // ---------------------------------------------------------------------------
  assign BR_EQ  = (RS1 == RS2);
  assign BR_LT  = ($signed(RS1) < $signed(RS2));
  assign BR_LTU = (RS1 < RS2);

`ifdef EXEC_BR_TAKEN_EN
  logic cond;

  always_comb begin
    cond = 1'b0;
    case (FUNCT3)
      F3_BEQ:  cond = BR_EQ;
      F3_BNE:  cond = ~BR_EQ;
      F3_BLT:  cond = BR_LT;
      F3_BGE:  cond = ~BR_LT;
      F3_BLTU: cond = BR_LTU;
      F3_BGEU: cond = ~BR_LTU;
      default: cond = 1'b0;
    endcase
  end

  assign BR_TAKEN = VALID & cond;
`endif

  // ---------------------------------------------------------------------------
  // EX/MEM result register: RST wins over EN, EN=0 holds.
  // ---------------------------------------------------------------------------
  logic [31:0] result_d, result_q;
  logic        valid_d,  valid_q;

  always_comb begin
    result_d = result_q;
    valid_d  = valid_q;
    if (RST) begin
      result_d = '0;
      valid_d  = 1'b0;
    end else if (EN) begin
      result_d = RESULT;
      valid_d  = VALID;
    end
  end

  // Reset is synchronous, so it is folded into result_d/valid_d above.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    result_q <= result_d;
    valid_q  <= valid_d;
  end

  assign RESULT_Q = result_q;
  assign VALID_Q  = valid_q;

endmodule

// File: tb/tb_otter_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_otter_exec_unit
// Self-checking bench for otter_exec_unit: directed corner cases plus random
// stimulus against a behavioural model. Honours EXEC_BR_TAKEN_EN.
// -----------------------------------------------------------------------------
module tb_otter_exec_unit;

  logic        clk = 1'b0;
  logic        rst, en, valid;
  logic [31:0] src_a, src_b, rs1, rs2, pc, i_type, b_type, j_type;
  logic [3:0]  alu_fun;
  logic [31:0] result, jal, jalr, branch, result_q;
  logic        br_eq, br_lt, br_ltu, valid_q;
`ifdef EXEC_BR_TAKEN_EN
  logic [2:0]  funct3;
  logic        br_taken;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard for the registered stage.
  logic [31:0] exp_rq;
  logic        exp_vq;

  always #5 clk = ~clk;

  otter_exec_unit dut (
    .CLK      (clk),
    .RST      (rst),
    .EN       (en),
    .VALID    (valid),
    .SRC_A    (src_a),
    .SRC_B    (src_b),
    .ALU_FUN  (alu_fun),
    .RS1      (rs1),
    .RS2      (rs2),
    .PC       (pc),
    .I_TYPE   (i_type),
    .B_TYPE   (b_type),
    .J_TYPE   (j_type),
`ifdef EXEC_BR_TAKEN_EN
    .FUNCT3   (funct3),
    .BR_TAKEN (br_taken),
`endif
    .RESULT   (result),
    .JAL      (jal),
    .JALR     (jalr),
    .BRANCH   (branch),
    .BR_EQ    (br_eq),
    .BR_LT    (br_lt),
    .BR_LTU   (br_ltu),
    .RESULT_Q (result_q),
    .VALID_Q  (valid_q)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] model_alu(input logic [3:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned s;
    logic [31:0] fill;
    s = int'(b % 32);
    case (f)
      4'd0:  return a + b;
      4'd8:  return a - b;
      4'd1:  return a << s;
      4'd2:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd5:  return a >> s;
      4'd13: begin
        fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0;
        return (a >> s) | fill;
      end
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd9:  return a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_taken(input logic [2:0] f3, input logic v,
                                       input logic [31:0] x, input logic [31:0] y);
    logic c;
    case (f3)
      3'd0: c = (x == y);
      3'd1: c = (x != y);
      3'd4: c = (int'(x) < int'(y));
      3'd5: c = (int'(x) >= int'(y));
      3'd6: c = (x < y);
      3'd7: c = (x >= y);
      default: c = 1'b0;
    endcase
    return v & c;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; valid = 1'b1;
    src_a = 32'd5; src_b = 32'd6; alu_fun = 4'd0;
    tick();
    checks++;
    if (result_q !== 32'd0) begin
      errors++; $display("FAIL reset_result_q got=%h exp=%h", result_q, 32'd0);
    end
    checks++;
    if (valid_q !== 1'b0) begin
      errors++; $display("FAIL reset_valid_q got=%b exp=0", valid_q);
    end
    rst = 1'b0;
    exp_rq = 32'd0; exp_vq = 1'b0;
  endtask

  task automatic test_alu_directed();
    logic [3:0]  f  [10] = '{4'd0, 4'd8, 4'd8, 4'd13, 4'd5, 4'd2, 4'd3, 4'd9, 4'd15, 4'd1};
    logic [31:0] a  [10] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1};
    logic [31:0] b  [10] = '{32'h1, 32'h1, 32'h1, 32'h24, 32'h24, 32'h1, 32'h1, 32'hDEAD_BEEF,
                             32'hFFFF_FFFF, 32'h3F};
    logic [31:0] ex [10] = '{32'h8000_0000, 32'h7FFF_FFFE, 32'hFFFF_FFFF, 32'hF800_0000,
                             32'h0800_0000, 32'h1, 32'h0, 32'h1234_5678, 32'h0, 32'h8000_0000};
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      alu_fun = f[i]; src_a = a[i]; src_b = b[i];
      #1;
      checks++;
      if (result !== ex[i]) begin
        errors++;
        $display("FAIL alu_dir[%0d] fun=%h got=%h exp=%h", i, f[i], result, ex[i]);
      end
    end
  endtask

  task automatic test_alu_random();
    logic [31:0] e;
    en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      alu_fun = 4'($urandom_range(0, 15));
      src_a = $urandom; src_b = $urandom;
      if (i % 4 == 0) src_a = {1'b1, src_a[30:0]};
      if (i % 5 == 0) src_b = src_a;
      #1;
      e = model_alu(alu_fun, src_a, src_b);
      checks++;
      if (result !== e) begin
        errors++;
        $display("FAIL alu_rand fun=%h a=%h b=%h got=%h exp=%h", alu_fun, src_a, src_b, result, e);
      end
    end
  endtask

  task automatic check_bag_bcg(input string tag);
    logic [31:0] ej, ejr, eb;
    logic        eeq, elt, eltu;
    ej   = pc + j_type;
    eb   = pc + b_type;
    ejr  = (rs1 + i_type) & 32'hFFFF_FFFE;
    eeq  = (rs1 == rs2);
    elt  = (int'(rs1) < int'(rs2));
    eltu = (rs1 < rs2);
    checks++;
    if (jal !== ej) begin errors++; $display("FAIL %s jal got=%h exp=%h", tag, jal, ej); end
    checks++;
    if (branch !== eb) begin errors++; $display("FAIL %s branch got=%h exp=%h", tag, branch, eb); end
    checks++;
    if (jalr !== ejr) begin errors++; $display("FAIL %s jalr got=%h exp=%h", tag, jalr, ejr); end
    checks++;
    if ({br_eq, br_lt, br_ltu} !== {eeq, elt, eltu}) begin
      errors++;
      $display("FAIL %s cmp got=%b%b%b exp=%b%b%b", tag, br_eq, br_lt, br_ltu, eeq, elt, eltu);
    end
  endtask

  task automatic test_bag_bcg();
    // Directed values from the plan, compared against literal expectations.
    pc = 32'h100; j_type = 32'hFFFF_FFF0; b_type = 32'h8; rs1 = 32'h203; i_type = 32'h0;
    rs2 = 32'h203;
    src_a = 32'h0; src_b = 32'h0;  // BCG must ignore these
    #1;
    checks++;
    if ({jal, branch, jalr} !== {32'hF0, 32'h108, 32'h202}) begin
      errors++;
      $display("FAIL bag_dir got=%h/%h/%h exp=000000f0/00000108/00000202", jal, branch, jalr);
    end
    checks++;
    if ({br_eq, br_lt, br_ltu} !== 3'b100) begin
      errors++; $display("FAIL bcg_equal got=%b%b%b exp=100", br_eq, br_lt, br_ltu);
    end
    rs1 = 32'hFFFF_FFFF; rs2 = 32'h1;
    #1;
    checks++;
    if ({br_eq, br_lt, br_ltu} !== 3'b010) begin
      errors++; $display("FAIL bcg_neg got=%b%b%b exp=010", br_eq, br_lt, br_ltu);
    end
    for (int i = 0; i < 100; i++) begin
      pc = $urandom; j_type = $urandom; b_type = $urandom; i_type = $urandom;
      rs1 = $urandom; rs2 = (i % 6 == 0) ? rs1 : $urandom;
      src_a = rs2; src_b = rs1;
      #1;
      check_bag_bcg("bag_bcg_rand");
    end
  endtask

  task automatic test_register_directed();
    // add 3+4 captured on one edge
    rst = 1'b0; en = 1'b1; valid = 1'b1;
    alu_fun = 4'd0; src_a = 32'd3; src_b = 32'd4;
    tick();
    checks++;
    if (result_q !== 32'd7 || valid_q !== 1'b1) begin
      errors++; $display("FAIL reg_capture got=%h/%b exp=00000007/1", result_q, valid_q);
    end
    // three stalled cycles with changing inputs
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      src_a = $urandom; src_b = $urandom; valid = 1'(i);
      tick();
      checks++;
      if (result_q !== 32'd7 || valid_q !== 1'b1) begin
        errors++; $display("FAIL reg_stall[%0d] got=%h/%b exp=00000007/1", i, result_q, valid_q);
      end
    end
    // reset asserted mid-stall clears the register
    rst = 1'b1;
    tick();
    checks++;
    if (result_q !== 32'd0 || valid_q !== 1'b0) begin
      errors++; $display("FAIL reg_rst_stall got=%h/%b exp=00000000/0", result_q, valid_q);
    end
    // release: exactly one capture; VALID=0 still captures RESULT
    rst = 1'b0; en = 1'b1; valid = 1'b0; src_a = 32'd10; src_b = 32'd3; alu_fun = 4'd8;
    tick();
    checks++;
    if (result_q !== 32'd7 || valid_q !== 1'b0) begin
      errors++; $display("FAIL reg_invalid_cap got=%h/%b exp=00000007/0", result_q, valid_q);
    end
    // RST has priority over EN
    rst = 1'b1; valid = 1'b1;
    tick();
    checks++;
    if (result_q !== 32'd0 || valid_q !== 1'b0) begin
      errors++; $display("FAIL reg_rst_prio got=%h/%b exp=00000000/0", result_q, valid_q);
    end
    rst = 1'b0;
    exp_rq = 32'd0; exp_vq = 1'b0;
  endtask

  task automatic test_register_random();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 19) == 0);
      en    = ($urandom_range(0, 9) < 6);
      valid = 1'($urandom);
      alu_fun = 4'($urandom_range(0, 15));
      src_a = $urandom; src_b = $urandom;
      if (rst) begin
        exp_rq = 32'd0; exp_vq = 1'b0;
      end else if (en) begin
        exp_rq = model_alu(alu_fun, src_a, src_b); exp_vq = valid;
      end
      tick();
      checks++;
      if (result_q !== exp_rq || valid_q !== exp_vq) begin
        errors++;
        $display("FAIL reg_rand[%0d] got=%h/%b exp=%h/%b", i, result_q, valid_q, exp_rq, exp_vq);
      end
    end
    rst = 1'b0;
  endtask

`ifdef EXEC_BR_TAKEN_EN
  task automatic test_br_taken();
    logic e;
    funct3 = 3'b101; rs1 = 32'hFFFF_FFFB; rs2 = 32'hFFFF_FFFB; valid = 1'b1;
    #1;
    checks++;
    if (br_taken !== 1'b1) begin errors++; $display("FAIL bt_bge_eq got=%b exp=1", br_taken); end
    valid = 1'b0;
    #1;
    checks++;
    if (br_taken !== 1'b0) begin errors++; $display("FAIL bt_invalid got=%b exp=0", br_taken); end
    valid = 1'b1; funct3 = 3'b010;
    #1;
    checks++;
    if (br_taken !== 1'b0) begin errors++; $display("FAIL bt_f3_010 got=%b exp=0", br_taken); end
    for (int i = 0; i < 200; i++) begin
      funct3 = 3'($urandom_range(0, 7)); valid = ($urandom_range(0, 3) != 0);
      rs1 = $urandom; rs2 = (i % 4 == 0) ? rs1 : $urandom;
      if (i % 3 == 0) rs2 = {~rs1[31], rs2[30:0]};
      #1;
      e = model_taken(funct3, valid, rs1, rs2);
      checks++;
      if (br_taken !== e) begin
        errors++;
        $display("FAIL bt_rand f3=%b v=%b rs1=%h rs2=%h got=%b exp=%b", funct3, valid, rs1, rs2, br_taken, e);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0;
    src_a = '0; src_b = '0; alu_fun = '0;
    rs1 = '0; rs2 = '0; pc = '0; i_type = '0; b_type = '0; j_type = '0;
`ifdef EXEC_BR_TAKEN_EN
    funct3 = '0;
`endif
    exp_rq = '0; exp_vq = 1'b0;
    #2;
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_bag_bcg();
    test_register_directed();
    test_register_random();
`ifdef EXEC_BR_TAKEN_EN
    test_br_taken();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
